// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller for a 32-bit combinational ALU.
// It holds an 8-entry register file (r0 hard-wired to zero) and steps each
// accepted command through IDLE -> READ -> EXEC -> WB. It drives registered
// operands to the ALU, captures the ALU flags, writes back the result and
// reports completion.
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. The command fields
// must be stable while cmd_valid is high. done_valid is a one-cycle pulse
// (the WB cycle) with no back-pressure.
module alu_issue_ctrl #(
   parameter int DATA_W = 32,
   parameter int NREG   = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs,
   input  logic [ADDR_W-1:0] cmd_rt,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_waddr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_flow,
   input  logic              alu_zero,
   output logic              done_valid,
   output logic [DATA_W-1:0] done_result,
   output logic              done_flow,
   output logic              done_err,
   output logic              branch_taken,
   output logic              ovf_sticky,
   input  logic              ovf_clr,
   input  logic [ADDR_W-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_READ = 2'b01;
   localparam logic [1:0] S_EXEC = 2'b10;
   localparam logic [1:0] S_WB   = 2'b11;

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_BEQ = 3'b100;
   localparam logic [2:0] OP_IL0 = 3'b011;
   localparam logic [2:0] OP_IL1 = 3'b101;

   logic [1:0]        r_state;
   logic [2:0]        r_op;
   logic [ADDR_W-1:0] r_rd;
   logic [ADDR_W-1:0] r_rs;
   logic [ADDR_W-1:0] r_rt;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [2:0]        r_alu_op;
   logic [DATA_W-1:0] r_done_result;
   logic              r_done_flow;
   logic              r_done_err;
   logic              r_branch;
   logic              r_ovf;
   logic [DATA_W-1:0] r_rf [NREG];

   logic w_accept;
   logic w_illegal;
   logic w_arith;
   logic w_wb_en;
   logic w_ext_en;

   assign w_accept  = (r_state == S_IDLE) && cmd_valid;
   assign w_illegal = (r_op == OP_IL0) || (r_op == OP_IL1);
   assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);
   // r0 is never written, so it keeps its reset value of zero forever.
   assign w_wb_en   = (r_state == S_WB) && !w_illegal && (r_op != OP_BEQ) &&
                      (r_rd != '0);
   assign w_ext_en  = (r_state == S_IDLE) && ext_we && (ext_waddr != '0);

   assign cmd_ready    = (r_state == S_IDLE);
   assign done_valid   = (r_state == S_WB);
   assign alu_a        = r_alu_a;
   assign alu_b        = r_alu_b;
   assign alu_op       = r_alu_op;
   assign done_result  = r_done_result;
   assign done_flow    = r_done_flow;
   assign done_err     = r_done_err;
   assign branch_taken = r_branch;
   assign ovf_sticky   = r_ovf;
   assign dbg_rdata    = r_rf[dbg_raddr];
   assign dbg_state    = r_state;

   // Main sequencer: one command every four cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (cmd_valid) r_state <= S_READ;
            S_READ:  r_state <= S_EXEC;
            S_EXEC:  r_state <= S_WB;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Latch the command fields on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op <= '0;
         r_rd <= '0;
         r_rs <= '0;
         r_rt <= '0;
      end else if (w_accept) begin
         r_op <= cmd_op;
         r_rd <= cmd_rd;
         r_rs <= cmd_rs;
         r_rt <= cmd_rt;
      end
   end

   // Present operands and opcode to the ALU. Illegal opcodes are passed through unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else if (r_state == S_READ) begin
         r_alu_a  <= r_rf[r_rs];
         r_alu_b  <= r_rf[r_rt];
         r_alu_op <= r_op;
      end
   end

   // Capture the ALU response at the end of EXEC. Flags are masked by opcode class here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_result <= '0;
         r_done_flow   <= 1'b0;
         r_done_err    <= 1'b0;
         r_branch      <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_done_result <= alu_out;
         r_done_flow   <= w_arith && alu_flow;
         r_done_err    <= w_illegal;
         r_branch      <= (r_op == OP_BEQ) && alu_zero;
      end
   end

   // Register file. External loads only in IDLE; the writeback happens at the end of WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (w_ext_en) begin
         r_rf[ext_waddr] <= ext_wdata;
      end else if (w_wb_en) begin
         r_rf[r_rd] <= r_done_result;
      end
   end

   // Sticky overflow. A set in WB takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if ((r_state == S_WB) && r_done_flow) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential issue and writeback controller placed directly upstream of the 32-bit combinational ALU (AND/OR/ADD/SUB/SLT/BEQ, with overflow and zero outputs).
- Holds an 8-entry register file, accepts one command per handshake, and drives registered operands and opcode into the ALU.
- Captures the ALU result, zero and overflow flags, writes the result back, and reports completion, branch decision and sticky overflow.

Parameters:
- DATA_W, 32, datapath and register width
- NREG, 8, register file depth
- ADDR_W, 3, register address width (log2 NREG)

Ports:
- clk in 1: single clock, rising edge
- rst_n in 1: asynchronous active-low reset
- cmd_valid in 1: command request
- cmd_ready out 1: controller can accept a command
- cmd_op in 3: ALU opcode (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 BEQ)
- cmd_rd in ADDR_W: destination register
- cmd_rs in ADDR_W: source A register
- cmd_rt in ADDR_W: source B register
- ext_we in 1: external register load strobe
- ext_waddr in ADDR_W: external load address
- ext_wdata in DATA_W: external load data
- alu_a out DATA_W: registered operand A to the ALU
- alu_b out DATA_W: registered operand B to the ALU
- alu_op out 3: registered opcode to the ALU
- alu_out in DATA_W: ALU result
- alu_flow in 1: ALU overflow
- alu_zero in 1: ALU zero flag
- done_valid out 1: one-cycle completion pulse
- done_result out DATA_W: captured result
- done_flow out 1: overflow of the completed command (masked)
- done_err out 1: completed command had an illegal opcode
- branch_taken out 1: BEQ outcome of the completed command
- ovf_sticky out 1: set on any arithmetic overflow
- ovf_clr in 1: clears ovf_sticky
- dbg_raddr in ADDR_W: debug read address
- dbg_rdata out DATA_W: combinational debug read of the register file

Behaviour:

Reset:
- On rst_n low, asynchronously clear the state to IDLE and all registers and outputs to 0.
- Reset asserted mid-command abandons the command with no writeback and no done_valid.
- cmd_ready is 1 in the first cycle after reset release.

Register file:
- r0 always reads 0; writes to r0 are discarded.
- dbg_rdata reflects the current contents of regfile[dbg_raddr].

FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- **IDLE:** cmd_ready=1. When cmd_valid is high, latch op, rd, rs and rt, then go to READ. When cmd_valid is low, stay in IDLE.
- **READ:** load alu_a=reg[rs], alu_b=reg[rt] and alu_op=op.
- **EXEC:** capture alu_out, alu_flow and alu_zero into internal registers.
- **WB:**
  - Write the result to rd.
  - Drive done_valid=1 for exactly one cycle, together with done_result, done_flow, done_err and branch_taken.
  - Return to IDLE.
- Latency from the accept edge to done_valid high is 3 cycles; throughput is 1 command per 4 cycles.
- cmd_ready is 0 in READ, EXEC and WB.

Opcode rules:
- 000, 001, 010, 110 and 111 write back the result.
- 100 (BEQ) has no writeback; branch_taken = captured zero flag.
- branch_taken is 0 for every non-BEQ command.
- done_flow = captured overflow only for 010 and 110; it is 0 otherwise.
- Illegal opcodes 011 and 101:
  - alu_op is still driven with the opcode.
  - No writeback; done_err=1, done_flow=0, branch_taken=0.

Overflow:
- On overflow the result is still written back.
- ovf_sticky sets in WB when done_flow=1.
- ovf_clr clears ovf_sticky on the next edge; a set in the same cycle wins.

External load:
- ext_we takes effect only in the IDLE state and is ignored in READ, EXEC and WB.
- If a command is accepted in the same cycle, the load still lands, and the READ of that command sees the new value.

Output hold:
- done_result, done_flow, done_err and branch_taken hold their values until the next WB.
- alu_a, alu_b and alu_op hold until the next READ.

Test Plan:
1. Load r1=10 and r2=136 via ext_we; issue ADD (010) rd=3 -> done_valid exactly 3 cycles after accept, done_result=146, done_flow=0, and dbg_raddr=3 reads 146.
2. Load r1=0x7FFFFFFF and r2=1; issue ADD rd=4 -> done_result=0x80000000, done_flow=1, ovf_sticky=1, r4 written. Then assert ovf_clr -> ovf_sticky=0 on the next edge.
3. Load r1=r2=-235; issue BEQ (100) rd=5 -> branch_taken=1, r5 unchanged. Change r2=-167 and reissue -> branch_taken=0.
4. Issue SLT (111) with r1=-207 and r2=-771 -> result 0. Then issue SUB (110) with r1=-207 and r2=738 -> result -945, done_flow=0.
5. Hold cmd_valid high continuously -> cmd_ready pattern 1,0,0,0 repeating. Issue a write to r0 -> r0 still reads 0. Issue opcode 011 -> done_err=1, no register changes.
6. Pull rst_n low during EXEC -> no done_valid, state IDLE, all registers read 0. Apply ext_we in EXEC of another command -> target register unchanged.
